// File: rtl/instr_aligner.sv
// Re-slices 32-bit fetch words into whole RV32IC instructions (16/32-bit)
// at any halfword alignment, with PC, compressed flag and redirect support.
module instr_aligner #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic            out_is_c
);

  logic [47:0]     buf_q;
  logic [47:0]     buf_sh;
  logic [47:0]     buf_n;
  logic [1:0]      cnt_q;
  logic [1:0]      cnt_after;
  logic [1:0]      cnt_n;
  logic [PC_W-1:0] head_pc_q;
  logic [PC_W-1:0] head_pc_n;
  logic            drop_q;
  logic            is_c;
  logic [1:0]      need;
  logic            fire_out;
  logic            fire_in;
  logic            unused_pc0;

  assign unused_pc0 = flush_pc[0];

  always_comb begin
    is_c      = (buf_q[1:0] != 2'b11);
    need      = is_c ? 2'd1 : 2'd2;
    out_valid = !flush && (cnt_q >= need);
    fire_out  = out_valid && out_ready;
    cnt_after = fire_out ? (cnt_q - need) : cnt_q;
    in_ready  = !flush && (cnt_after <= 2'd1);
    fire_in   = in_valid && in_ready;
  end

  assign out_instr = is_c ? {16'h0, buf_q[15:0]} : buf_q[31:0];
  assign out_pc    = head_pc_q;
  // Empty buffer holds zeros, which would otherwise read as compressed
  assign out_is_c  = is_c && (cnt_q != 2'd0);

  always_comb begin
    buf_sh    = buf_q;
    head_pc_n = head_pc_q;
    if (fire_out) begin
      buf_sh    = is_c ? {16'h0, buf_q[47:16]} : {32'h0, buf_q[47:32]};
      head_pc_n = head_pc_q + PC_W'({need, 1'b0});
    end
  end

  // New halfwords land right above whatever survives this cycle's consume
  always_comb begin
    buf_n = buf_sh;
    cnt_n = cnt_after;
    if (fire_in) begin
      if (drop_q) begin
        if (cnt_after[0]) buf_n[31:16] = in_data[31:16];
        else              buf_n[15:0]  = in_data[31:16];
        cnt_n = cnt_after + 2'd1;
      end else begin
        if (cnt_after[0]) buf_n[47:16] = in_data;
        else              buf_n[31:0]  = in_data;
        cnt_n = cnt_after + 2'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q     <= '0;
      cnt_q     <= 2'd0;
      head_pc_q <= RESET_PC;
      drop_q    <= RESET_PC[1];
    end else if (flush) begin
      cnt_q     <= 2'd0;
      head_pc_q <= {flush_pc[PC_W-1:1], 1'b0};
      drop_q    <= flush_pc[1];
    end else begin
      buf_q     <= buf_n;
      cnt_q     <= cnt_n;
      head_pc_q <= head_pc_n;
      if (fire_in) drop_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner: halfword-queue reference model,
// directed scenarios plus randomized traffic with flushes and backpressure.
module tb_instr_aligner;

  localparam int          PC_W   = 32;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_c;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] hw;
  } hw_t;

  hw_t         hq[$];
  logic [31:0] m_pc;
  logic        m_drop;

  instr_aligner #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_is_c(out_is_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: buffered halfwords with their addresses, in fetch order
  task automatic model_step();
    int          sz;
    int          need;
    int          after;
    bit          ec;
    bit          ev;
    bit          fo;
    bit          eir;
    logic [31:0] ei;
    logic [31:0] hpc;
    sz   = hq.size();
    ec   = (sz > 0) && (hq[0].hw[1:0] != 2'b11);
    need = ec ? 1 : 2;
    ev   = !flush && (sz > 0) && (sz >= need);
    hpc  = (sz > 0) ? hq[0].pc : m_pc;
    chk("out_valid", out_valid, ev);
    chk("out_pc", out_pc, hpc);
    if (ev) begin
      ei = ec ? {16'h0, hq[0].hw} : {hq[1].hw, hq[0].hw};
      chk("out_instr", out_instr, ei);
      chk("out_is_c", out_is_c, ec);
    end
    fo    = ev && out_ready;
    after = sz - (fo ? need : 0);
    eir   = !flush && (after <= 1);
    chk("in_ready", in_ready, eir);
    if (flush) begin
      hq.delete();
      m_pc   = {flush_pc[31:1], 1'b0};
      m_drop = flush_pc[1];
    end else begin
      if (fo) repeat (need) void'(hq.pop_front());
      if (in_valid && eir) begin
        if (!m_drop) begin
          hq.push_back('{m_pc, in_data[15:0]});
          m_pc += 32'd2;
        end
        hq.push_back('{m_pc, in_data[31:16]});
        m_pc += 32'd2;
        m_drop = 1'b0;
      end
    end
  endtask

  // Monitor: samples one time unit before each rising edge
  initial begin
    m_pc   = RST_PC;
    m_drop = RST_PC[1];
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        hq.delete();
        m_pc   = RST_PC;
        m_drop = RST_PC[1];
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, RST_PC);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_is_c", out_is_c, 0);
      end else begin
        model_step();
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic r,
                       input logic f, input logic [31:0] fp);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    flush_pc  = fp;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) drive(1'b0, 32'h0, r, 1'b0, 32'h0);
  endtask

  task automatic send_word(input logic [31:0] d, input int rdy_pct);
    int n;
    bit acc;
    n   = 0;
    acc = 0;
    while (!acc) begin
      drive(1'b1, d, ($urandom_range(99) < rdy_pct), 1'b0, 32'h0);
      #3;
      acc = in_ready;
      n++;
      if (!acc && n > 40) begin
        total++;
        bad++;
        $display("FAIL send_timeout: actual=stuck required=accept d=%h", d);
        acc = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] cword();
    logic [31:0] w;
    w        = $urandom;
    w[1:0]   = 2'($urandom_range(2));
    w[17:16] = 2'($urandom_range(2));
    return w;
  endfunction

  function automatic logic [31:0] rword();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(1) == 0) w[1:0] = 2'b11;
    if ($urandom_range(1) == 0) w[17:16] = 2'b11;
    return w;
  endfunction

  initial begin
    idle(2, 1'b0);
    reset = 1'b0;

    // straight 32-bit stream
    send_word(32'h00500093, 100);
    send_word(32'h00108113, 100);
    idle(3, 1'b1);

    // compressed pair
    do_reset();
    send_word(32'h00014085, 100);
    idle(3, 1'b1);

    // straddling 32-bit instruction
    do_reset();
    send_word(32'h00934085, 100);
    idle(2, 1'b1);
    send_word(32'h00010050, 100);
    idle(3, 1'b1);

    // flush to odd halfword with buffered pre-flush content
    do_reset();
    send_word(32'h00014085, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h103);
    send_word(32'h4085ABCD, 100);
    idle(4, 1'b1);

    // pc wraps through zero
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    send_word(32'h00500093, 100);
    send_word(32'h00108113, 100);
    idle(3, 1'b1);

    // backpressure on compressed stream
    do_reset();
    repeat (5) drive(1'b1, cword(), 1'b0, 1'b0, 32'h0);
    repeat (8) drive(1'b1, cword(), 1'b1, 1'b0, 32'h0);
    idle(4, 1'b1);

    // async reset with three halfwords buffered
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2);
    send_word(32'h00930000, 0);
    send_word(32'h40850050, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_pc", out_pc, RST_PC);
    @(negedge clk);
    reset = 1'b0;
    send_word(32'h00500093, 100);
    idle(3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(9) < 7,
              ($urandom_range(1) == 0) ? cword() : rword(),
              $urandom_range(9) < 7,
              $urandom_range(99) < 3,
              {20'h0, 12'($urandom)});
      end
    end
    idle(4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
